rsa_job_sequencer: RTL and testbench

//  Upstream front-end for the RSA modular-exponentiation core. Holds exponent/modulus

---
 rtl/rsa_pkg.sv | 16 +
 rtl/rsa_seq_fifo.sv | 60 ++++++
 rtl/rsa_job_sequencer.sv | 178 +++++++++++++++++
 tb/tb_rsa_job_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and default parameters for the RSA job sequencer front-end.
package rsa_pkg;

   localparam int RSA_DW         = 6;
   localparam int RSA_FIFO_DEPTH = 4;
   localparam int RSA_TIMEOUT    = 255;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      LAUNCH = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_e;

endpackage

// File: rtl/rsa_seq_fifo.sv
// Synchronous count-based FIFO holding plaintext words ahead of the sequencer FSM.
module rsa_seq_fifo #(
   parameter int DW    = 6,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/rsa_job_sequencer.sv
// Front-end for the RSA modexp core: queues plaintext, validates each job against the
// loaded key/modulus, launches the core once per word and returns results on a stream.
module rsa_job_sequencer
   import rsa_pkg::*;
#(
   parameter int DW         = RSA_DW,
   parameter int FIFO_DEPTH = RSA_FIFO_DEPTH,
   parameter int TIMEOUT    = RSA_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [DW-1:0] cfg_key,
   input  logic [DW-1:0] cfg_n,
   output logic          cfg_err,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          core_start,
   output logic [DW-1:0] core_data,
   output logic [DW-1:0] core_key,
   output logic [DW-1:0] core_n,
   input  logic          core_done,
   input  logic [DW-1:0] core_result,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_err,
   input  logic          out_ready,
   output state_e        dbg_state
);

   // Streams use valid/ready: a word transfers on any edge where both are high;
   // the producer holds valid and data stable until that edge.

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   logic [DW-1:0] key_q, key_d;
   logic [DW-1:0] n_q, n_d;
   logic          cfg_valid_q, cfg_valid_d;
   logic          cfg_err_q, cfg_err_d;
   logic [DW-1:0] data_q, data_d;
   logic          start_q, start_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_err_q, out_err_d;

   logic [DW-1:0] fifo_rdata;
   logic          fifo_full, fifo_empty;
   logic          job_bad;

   rsa_seq_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (state_q == CHECK),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign job_bad = !cfg_valid_q || (key_q == '0) || (n_q < DW'(2)) || (fifo_rdata >= n_q);

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      n_d         = n_q;
      cfg_valid_d = cfg_valid_q;
      cfg_err_d   = 1'b0;
      data_d      = data_q;
      start_d     = 1'b0;
      timer_d     = timer_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;

      // Key/modulus may only change when no job is queued or running.
      if (cfg_we) begin
         if (state_q == IDLE && fifo_empty) begin
            key_d       = cfg_key;
            n_d         = cfg_n;
            cfg_valid_d = 1'b1;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (!fifo_empty && !out_valid_q) state_d = CHECK;
         end
         CHECK: begin
            data_d = fifo_rdata;
            if (job_bad) begin
               out_valid_d = 1'b1;
               out_err_d   = 1'b1;
               out_data_d  = '0;
               state_d     = RESP;
            end else begin
               start_d = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // timer_q == 0 marks the first WAIT cycle, where done may be stale.
            if (timer_q != '0 && core_done) begin
               out_valid_d = 1'b1;
               out_err_d   = 1'b0;
               out_data_d  = core_result;
               state_d     = RESP;
            end else if (timer_q >= TW'(TIMEOUT)) begin
               out_valid_d = 1'b1;
               out_err_d   = 1'b1;
               out_data_d  = '0;
               state_d     = RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         key_q       <= '0;
         n_q         <= '0;
         cfg_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         data_q      <= '0;
         start_q     <= 1'b0;
         timer_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         n_q         <= n_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_err_q   <= cfg_err_d;
         data_q      <= data_d;
         start_q     <= start_d;
         timer_q     <= timer_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
      end
   end

   assign cfg_err    = cfg_err_q;
   assign in_ready   = !fifo_full;
   assign core_start = start_q;
   assign core_data  = data_q;
   assign core_key   = key_q;
   assign core_n     = n_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_err    = out_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Directed bench for rsa_job_sequencer with a behavioural modexp core and result scoreboard.
module tb_rsa_job_sequencer;
   import rsa_pkg::*;

   localparam int DW  = 6;
   localparam int TMO = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [DW-1:0] cfg_key = '0, cfg_n = '0;
   logic          cfg_err;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          core_start;
   logic [DW-1:0] core_data, core_key, core_n;
   logic          core_done = 1'b0;
   logic [DW-1:0] core_result = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_err;
   logic          out_ready = 1'b1;
   state_e        dbg_state;

   rsa_job_sequencer dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_key(cfg_key), .cfg_n(cfg_n),
      .cfg_err(cfg_err), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .core_start(core_start), .core_data(core_data), .core_key(core_key),
      .core_n(core_n), .core_done(core_done), .core_result(core_result),
      .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
      .out_ready(out_ready), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests_run = 0;
   int fails = 0;
   int start_cnt = 0;
   int start_cyc = 0;
   int last_out_cyc = 0;
   logic prev_start = 1'b0;

   logic [DW:0] exp_q[$];
   logic          m_cfg_valid = 1'b0;
   logic [DW-1:0] m_key = '0, m_n = '0;

   // Core model: 0 = answers after core_lat cycles, 1 = stale done lingers one cycle
   // after start, 2 = never answers.
   int            core_mode = 0;
   int            core_lat = 3;
   logic          preset_stale = 1'b0;
   logic          cm_busy = 1'b0, cm_drop = 1'b0;
   int            cm_cnt = 0;
   logic [DW-1:0] cm_res = '0;

   function automatic logic [DW-1:0] modexp(input logic [DW-1:0] b, e, n);
      int r = 1;
      if (n == 0) return '0;
      for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(n);
      return r[DW-1:0];
   endfunction

   function automatic logic [DW:0] exp_for(input logic [DW-1:0] d);
      if (!m_cfg_valid || m_key == 0 || m_n < 2 || d >= m_n) return {1'b1, {DW{1'b0}}};
      return {1'b0, modexp(d, m_key, m_n)};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         core_done <= 1'b0;
         cm_busy   <= 1'b0;
         cm_drop   <= 1'b0;
      end else if (preset_stale) begin
         core_done   <= 1'b1;
         core_result <= 6'h3F;
      end else if (core_start) begin
         cm_busy <= 1'b1;
         cm_cnt  <= core_lat;
         cm_res  <= modexp(core_data, core_key, core_n);
         if (core_mode == 1) cm_drop <= 1'b1;
         else core_done <= 1'b0;
      end else begin
         if (cm_drop) begin
            core_done <= 1'b0;
            cm_drop   <= 1'b0;
         end
         if (cm_busy && core_mode != 2) begin
            if (cm_cnt <= 1) begin
               core_done   <= 1'b1;
               core_result <= cm_res;
               cm_busy     <= 1'b0;
            end else begin
               cm_cnt <= cm_cnt - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
            tests_run++;
            assert (prev_start === 1'b0) else begin
               fails++;
               $error("FAIL start_width observed=%0d expected=0", prev_start);
            end
         end
         prev_start = core_start;
         if (out_valid && out_ready) begin
            tests_run++;
            last_out_cyc = cyc;
            if (exp_q.size() == 0) begin
               fails++;
               $error("FAIL out_unexpected observed=%0h expected=none", {out_err, out_data});
            end else begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               assert ({out_err, out_data} === e) else begin
                  fails++;
                  $error("FAIL out_word observed=%0h expected=%0h", {out_err, out_data}, e);
               end
            end
         end
      end else begin
         prev_start = 1'b0;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_cfg(input logic [DW-1:0] k, input logic [DW-1:0] n, input logic ok);
      cfg_we  = 1'b1;
      cfg_key = k;
      cfg_n   = n;
      tick(1);
      cfg_we = 1'b0;
      check("cfg_err", cfg_err, !ok);
      if (ok) begin
         m_key = k;
         m_n = n;
         m_cfg_valid = 1'b1;
         check("core_key", core_key, k);
         check("core_n", core_n, n);
      end
      tick(1);
      check("cfg_err_clear", cfg_err, 0);
   endtask

   task automatic push(input logic [DW-1:0] d, input logic sb, input logic force_err);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) check("push_ready_timeout", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      if (sb) exp_q.push_back(force_err ? {1'b1, {DW{1'b0}}} : exp_for(d));
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || dbg_state != IDLE) && n < budget) begin
         tick(1);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      check("drain_idle", dbg_state, IDLE);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      m_cfg_valid = 1'b0;
      m_key = '0;
      m_n = '0;
      exp_q.delete();
      tick(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int n;
      tick(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_err", out_err, 0);
      check("rst_out_data", out_data, 0);
      check("rst_core_start", core_start, 0);
      check("rst_core_key", core_key, 0);
      check("rst_core_n", core_n, 0);
      check("rst_core_data", core_data, 0);
      check("rst_cfg_err", cfg_err, 0);
      rst = 1'b0;
      tick(1);
      check("rst_in_ready", in_ready, 1);
      check("rst_state", dbg_state, IDLE);

      // Test 1: single job
      do_cfg(6'd5, 6'd33, 1'b1);
      s0 = start_cnt;
      push(6'd2, 1'b1, 1'b0);
      drain(100);
      check("t1_starts", start_cnt - s0, 1);

      // Test 2: back-to-back words, ordered results
      do_cfg(6'd3, 6'd55, 1'b1);
      s0 = start_cnt;
      check("t2_ready0", in_ready, 1);
      push(6'd4, 1'b1, 1'b0);
      check("t2_ready1", in_ready, 1);
      push(6'd9, 1'b1, 1'b0);
      check("t2_ready2", in_ready, 1);
      push(6'd1, 1'b1, 1'b0);
      drain(200);
      check("t2_starts", start_cnt - s0, 3);

      // Test 3: job without config is rejected, then succeeds after config
      reset_dut();
      s0 = start_cnt;
      push(6'd7, 1'b1, 1'b0);
      drain(100);
      check("t3_nostart", start_cnt - s0, 0);
      do_cfg(6'd1, 6'd10, 1'b1);
      push(6'd7, 1'b1, 1'b0);
      drain(100);
      check("t3_starts", start_cnt - s0, 1);

      // Test 4: data >= N rejected; cfg_we during RESP rejected
      do_cfg(6'd5, 6'd33, 1'b1);
      out_ready = 1'b0;
      s0 = start_cnt;
      push(6'd40, 1'b1, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         tick(1);
         n++;
      end
      check("t4_out_valid", out_valid, 1);
      do_cfg(6'd7, 6'd20, 1'b0);
      check("t4_key_kept", core_key, 5);
      check("t4_n_kept", core_n, 33);
      check("t4_hold", {out_valid, out_err, out_data}, {1'b1, 1'b1, 6'd0});
      out_ready = 1'b1;
      drain(100);
      check("t4_nostart", start_cnt - s0, 0);

      // Test 5a: stale done held across launch is ignored
      core_mode = 1;
      core_lat = 20;
      preset_stale = 1'b1;
      tick(1);
      preset_stale = 1'b0;
      check("t5_stale_done", core_done, 1);
      s0 = start_cnt;
      push(6'd2, 1'b1, 1'b0);
      drain(200);
      check("t5_starts", start_cnt - s0, 1);

      // Test 5b: core never answers -> timeout error
      core_mode = 2;
      push(6'd3, 1'b1, 1'b1);
      drain(600);
      n = last_out_cyc - start_cyc;
      check("t5_tmo_lat", (n >= TMO && n <= TMO + 3), 1);

      // Test 6: backpressure fills the queue behind one job in flight
      core_mode = 0;
      core_lat = 3;
      out_ready = 1'b0;
      push(6'd2, 1'b1, 1'b0);
      push(6'd3, 1'b1, 1'b0);
      push(6'd4, 1'b1, 1'b0);
      push(6'd5, 1'b1, 1'b0);
      check("t6_ready_before_full", in_ready, 1);
      push(6'd6, 1'b1, 1'b0);
      check("t6_full", in_ready, 0);
      in_valid = 1'b1;
      in_data = 6'd7;
      tick(10);
      check("t6_still_full", in_ready, 0);
      check("t6_resp_held", out_valid, 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain(300);

      // Test 6b: reset in the middle of WAIT flushes everything
      core_mode = 2;
      push(6'd9, 1'b0, 1'b0);
      push(6'd10, 1'b0, 1'b0);
      push(6'd11, 1'b0, 1'b0);
      n = 0;
      while (dbg_state != WAIT && n < 50) begin
         tick(1);
         n++;
      end
      check("t6_in_wait", dbg_state, WAIT);
      rst = 1'b1;
      tick(1);
      s0 = start_cnt;
      check("t6r_out_valid", out_valid, 0);
      check("t6r_core_start", core_start, 0);
      check("t6r_out_err", out_err, 0);
      check("t6r_out_data", out_data, 0);
      check("t6r_state", dbg_state, IDLE);
      check("t6r_in_ready", in_ready, 1);
      check("t6r_key", core_key, 0);
      rst = 1'b0;
      m_cfg_valid = 1'b0;
      tick(20);
      check("t6r_nostart", start_cnt - s0, 0);
      check("t6r_no_out", out_valid, 0);
      check("t6r_exp_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
